// File: rtl/ring_receiver_if.sv
// Bundle of the upstream link, downstream link and local eject port of one ring stop.
// The packet is carried flat; the receiver overlays its own {dest, pid} struct on it.
interface ring_receiver_if #(
  parameter int PKT_W = 35
);
  logic             link_in_valid;
  logic [PKT_W-1:0] link_in_pkt;
  logic             link_in_credit;
  logic             link_out_valid;
  logic [PKT_W-1:0] link_out_pkt;
  logic             link_out_ready;
  logic             eject_valid;
  logic [PKT_W-1:0] eject_pkt;
  logic             eject_ready;
  logic             received;
  logic [31:0]      pid_received;
  logic             err_overflow;
  logic             err_bad_dest;

  modport master (
    output link_in_valid, link_in_pkt, link_out_ready, eject_ready,
    input  link_in_credit, link_out_valid, link_out_pkt, eject_valid, eject_pkt,
           received, pid_received, err_overflow, err_bad_dest
  );

  modport slave (
    input  link_in_valid, link_in_pkt, link_out_ready, eject_ready,
    output link_in_credit, link_out_valid, link_out_pkt, eject_valid, eject_pkt,
           received, pid_received, err_overflow, err_bad_dest
  );
endinterface

// File: rtl/ring_receiver.sv
// Receive side of a ring stop: credit-controlled input buffer whose head is either
// ejected locally, forwarded downstream, or discarded when its destination does not exist.
module ring_receiver #(
  parameter int NUM_PROC = 8,
  parameter int NODE_ID  = 0,
  parameter int DEPTH    = 4
) (
  input logic            clk,
  input logic            reset,
  ring_receiver_if.slave bus
);
  localparam int DW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [DW:0]   NUM_PROC_L = (DW+1)'(NUM_PROC);
  localparam logic [DW-1:0] NODE_L     = DW'(NODE_ID);

  typedef struct packed {
    logic [DW-1:0] dest;
    logic [31:0]   pid;
  } pkt_t;

  pkt_t          ib_mem [DEPTH];
  logic [AW-1:0] ib_wr_ptr;
  logic [AW-1:0] ib_rd_ptr;
  logic [AW:0]   ib_count;

  pkt_t          eb_mem [DEPTH];
  logic [AW-1:0] eb_wr_ptr;
  logic [AW-1:0] eb_rd_ptr;
  logic [AW:0]   eb_count;

  pkt_t in_pkt;
  pkt_t ib_head;
  pkt_t eb_head;
  logic ib_empty;
  logic head_local;
  logic head_bad;
  logic head_fwd;
  logic eb_full;
  logic eb_pop;
  logic eb_push;
  logic ib_deq;
  logic ib_wr;

  assign in_pkt  = pkt_t'(bus.link_in_pkt);
  assign ib_head = ib_mem[ib_rd_ptr];
  assign eb_head = eb_mem[eb_rd_ptr];

  // The head is classified every cycle; exactly one class applies when the buffer is non-empty.
  assign ib_empty   = (ib_count == '0);
  assign head_bad   = !ib_empty && ({1'b0, ib_head.dest} >= NUM_PROC_L);
  assign head_local = !ib_empty && !head_bad && (ib_head.dest == NODE_L);
  assign head_fwd   = !ib_empty && !head_bad && !head_local;

  assign eb_full = (eb_count == DEPTH_L);
  assign eb_pop  = (eb_count != '0) && bus.eject_ready;
  assign eb_push = head_local && (!eb_full || eb_pop);

  assign ib_deq = head_bad || eb_push || (head_fwd && bus.link_out_ready);
  assign ib_wr  = bus.link_in_valid && ((ib_count < DEPTH_L) || ib_deq);

  assign bus.link_out_valid = head_fwd;
  assign bus.link_out_pkt   = ib_head;
  assign bus.eject_valid    = (eb_count != '0);
  assign bus.eject_pkt      = eb_head;

  // Storage arrays need no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (ib_wr)   ib_mem[ib_wr_ptr] <= in_pkt;
    if (eb_push) eb_mem[eb_wr_ptr] <= ib_head;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ib_wr_ptr          <= '0;
      ib_rd_ptr          <= '0;
      ib_count           <= '0;
      eb_wr_ptr          <= '0;
      eb_rd_ptr          <= '0;
      eb_count           <= '0;
      bus.link_in_credit <= 1'b0;
      bus.received       <= 1'b0;
      bus.pid_received   <= '0;
      bus.err_overflow   <= 1'b0;
      bus.err_bad_dest   <= 1'b0;
    end else begin
      if (ib_wr)   ib_wr_ptr <= ib_wr_ptr + AW'(1);
      if (ib_deq)  ib_rd_ptr <= ib_rd_ptr + AW'(1);
      if (eb_push) eb_wr_ptr <= eb_wr_ptr + AW'(1);
      if (eb_pop)  eb_rd_ptr <= eb_rd_ptr + AW'(1);

      unique case ({ib_wr, ib_deq})
        2'b10:   ib_count <= ib_count + (AW+1)'(1);
        2'b01:   ib_count <= ib_count - (AW+1)'(1);
        default: ib_count <= ib_count;
      endcase

      unique case ({eb_push, eb_pop})
        2'b10:   eb_count <= eb_count + (AW+1)'(1);
        2'b01:   eb_count <= eb_count - (AW+1)'(1);
        default: eb_count <= eb_count;
      endcase

      // One credit per freed input slot, regardless of where the packet went.
      bus.link_in_credit <= ib_deq;
      bus.received       <= eb_pop;
      if (eb_pop) bus.pid_received <= eb_head.pid;

      if (bus.link_in_valid && !ib_wr) bus.err_overflow <= 1'b1;
      if (head_bad)                    bus.err_bad_dest <= 1'b1;
    end
  end
endmodule
